ch8_add_sched: RTL

- Round-robin scheduler that time-shares one external 8-lane signed adder (ch8_adder) among NREQ requesters in ip_fdt.
- Each requester presents an operand pair over a valid/ready handshake.
- The block grants one requester at a time and drives the shared adder's A/B inputs. It registers the adder's combinational sum and returns it with the requester ID over a valid/ready response channel.

---
 rtl/ch8_add_sched.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/ch8_add_sched.sv
// ch8_add_sched
// Round-robin scheduler that time-shares one external 8-lane signed adder
// (ch8_adder) among NREQ requesters. The granted requester's operands are
// muxed onto add_a/add_b, the adder's combinational sum (add_z) is registered
// together with the requester index, and returned over a valid/ready channel.
//
// State table:
//   state  | meaning
//   IDLE   | no response held; any valid request may be granted
//   HOLD   | response held (rsp_vld=1); a new grant only in a cycle with rsp_rdy=1
//
// Ports:
//   clk, rst          clock (rising edge), asynchronous active-high reset
//   req_vld/req_rdy   per-requester handshake (req_rdy one-hot or zero)
//   req_a/req_b       operands, requester i at [i*8*DW +: 8*DW]
//   add_a/add_b       to shared adder inputs (0 when no grant)
//   add_z             from shared adder output (combinational)
//   rsp_vld/rsp_rdy   response handshake
//   rsp_id/rsp_z      owning requester index and registered lane sums
//   sat_flag          per-lane overflow flags (only with CH8_ADD_SCHED_SAT_EN)
//   busy              high while a response is held
//
// Build option: define CH8_ADD_SCHED_SAT_EN to saturate overflowed lanes
// instead of returning the wrapped sum, and to add the sat_flag output.

module ch8_add_sched #(
    parameter int DW   = 8,
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_vld,
    output logic [NREQ-1:0]      req_rdy,
    input  logic [NREQ*8*DW-1:0] req_a,
    input  logic [NREQ*8*DW-1:0] req_b,
    output logic [8*DW-1:0]      add_a,
    output logic [8*DW-1:0]      add_b,
    input  logic [8*DW-1:0]      add_z,
    output logic                 rsp_vld,
    input  logic                 rsp_rdy,
    output logic [IDW-1:0]       rsp_id,
    output logic [8*DW-1:0]      rsp_z,
`ifdef CH8_ADD_SCHED_SAT_EN
    output logic [7:0]           sat_flag,
`endif
    output logic                 busy
);

    localparam int LW = 8 * DW;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_HOLD = 1'b1
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic [IDW-1:0] ptr;
    logic [IDW-1:0] ptr_nxt;
    logic [IDW-1:0] gnt_idx;
    logic           gnt_vld;
    logic           grant_ok;
    int             arb_idx;
    logic [LW-1:0]  rsp_z_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Arbitration, next state and handshake outputs. Reset gates the grant so
    // req_rdy drops immediately while rst is high, even though state is IDLE.
    always_comb begin
        gnt_vld   = 1'b0;
        gnt_idx   = '0;
        arb_idx   = 0;
        req_rdy   = '0;
        add_a     = '0;
        add_b     = '0;
        state_nxt = state;
        grant_ok  = !rst && ((state == S_IDLE) || rsp_rdy);

        if (grant_ok) begin
            for (int k = 0; k < NREQ; k++) begin
                arb_idx = int'(ptr) + k;
                if (arb_idx >= NREQ) begin
                    arb_idx = arb_idx - NREQ;
                end
                if (!gnt_vld && req_vld[arb_idx]) begin
                    gnt_vld = 1'b1;
                    gnt_idx = IDW'(arb_idx);
                end
            end
        end

        if (gnt_vld) begin
            req_rdy[gnt_idx] = 1'b1;
            add_a            = req_a[int'(gnt_idx)*LW +: LW];
            add_b            = req_b[int'(gnt_idx)*LW +: LW];
            state_nxt        = S_HOLD;
        end else if (state == S_HOLD && rsp_rdy) begin
            state_nxt = S_IDLE;
        end
    end

    assign ptr_nxt = (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
    assign rsp_vld = (state == S_HOLD);
    assign busy    = (state == S_HOLD);

`ifdef CH8_ADD_SCHED_SAT_EN
    logic [7:0] ovf;

    // Signed overflow: operands agree in sign and the sum disagrees. The
    // clamp direction follows the sign of a (equal to the sign of b here).
    always_comb begin
        ovf       = '0;
        rsp_z_nxt = add_z;
        for (int l = 0; l < 8; l++) begin
            ovf[l] = (add_a[l*DW+DW-1] == add_b[l*DW+DW-1]) &&
                     (add_z[l*DW+DW-1] != add_a[l*DW+DW-1]);
            if (ovf[l]) begin
                rsp_z_nxt[l*DW +: DW] = add_a[l*DW+DW-1] ? {1'b1, {(DW-1){1'b0}}}
                                                         : {1'b0, {(DW-1){1'b1}}};
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sat_flag <= '0;
        end else if (gnt_vld) begin
            sat_flag <= ovf;
        end
    end
`else
    assign rsp_z_nxt = add_z;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_z  <= '0;
            rsp_id <= '0;
            ptr    <= '0;
        end else if (gnt_vld) begin
            rsp_z  <= rsp_z_nxt;
            rsp_id <= gnt_idx;
            ptr    <= ptr_nxt;
        end
    end

endmodule
